// File: rtl/cpu_sequencer.sv
// Control sequencer for the 6-bit-address / 8-bit-data adding-machine CPU.
// Moore FSM stepping fetch, decode and execute, plus halt detection and a retired-instruction counter.
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic [7:0]       ir,
    input  logic [5:0]       pc,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             ac_ld,
    output logic             ac_sel,
    output logic             adr_sel,
    output logic             rd_mem,
    output logic             wr_mem,
    output logic             halted,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_DECODE   = 3'd2;
    localparam logic [2:0] S_EXEC_RD  = 3'd3;
    localparam logic [2:0] S_EXEC_WR  = 3'd4;
    localparam logic [2:0] S_EXEC_JMP = 3'd5;
    localparam logic [2:0] S_HALT     = 3'd6;

    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] count_reg;
    logic [5:0]       pc_prev;
    logic             self_jump;
    logic             exec_exit;
    logic [2:0]       boundary_next;

    // pc has already been incremented by the fetch, so the jmp's own address is pc-1 (mod 64).
    assign pc_prev       = pc - 6'd1;
    assign self_jump     = (ir[5:0] == pc_prev);
    assign boundary_next = hold ? S_IDLE : S_FETCH;
    assign exec_exit     = (state_reg == S_EXEC_RD) || (state_reg == S_EXEC_WR) ||
                           (state_reg == S_EXEC_JMP);

    always_comb begin
        state_next = S_IDLE;
        case (state_reg)
            S_IDLE:     state_next = boundary_next;
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                case (ir[7:6])
                    2'b00, 2'b01: state_next = S_EXEC_RD;
                    2'b10:        state_next = S_EXEC_WR;
                    default:      state_next = S_EXEC_JMP;
                endcase
            end
            S_EXEC_RD:  state_next = boundary_next;
            S_EXEC_WR:  state_next = boundary_next;
            S_EXEC_JMP: state_next = self_jump ? S_HALT : boundary_next;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (exec_exit) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    // Every control output is a pure decode of the registered state.
    always_comb begin
        ir_ld   = 1'b0;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        ac_ld   = 1'b0;
        ac_sel  = 1'b0;
        adr_sel = 1'b0;
        rd_mem  = 1'b0;
        wr_mem  = 1'b0;
        halted  = 1'b0;
        case (state_reg)
            S_FETCH: begin
                rd_mem = 1'b1;
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            S_EXEC_RD: begin
                rd_mem  = 1'b1;
                adr_sel = 1'b1;
                ac_ld   = 1'b1;
                ac_sel  = ~ir[6];
            end
            S_EXEC_WR: begin
                wr_mem  = 1'b1;
                adr_sel = 1'b1;
            end
            S_EXEC_JMP: pc_ld  = 1'b1;
            S_HALT:     halted = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg   = state_reg;
    assign instr_count = count_reg;

endmodule
